// File: rtl/alu_exec_unit.sv
// Registered RV-style execute unit: ALU, branch compare and, when ALU_MDU_EN is defined,
// an iterative shift-add multiplier / restoring divider with a start/busy/done handshake.
module alu_exec_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [3:0]      fmt,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            branch_taken,
  output logic            illegal
);
  localparam int SW = $clog2(XLEN);

  logic [XLEN-1:0] aluRes;
  logic [XLEN-1:0] sraRes;
  logic            aluBr;
  logic            aluIll;
  logic [XLEN-1:0] result_q;
  logic            done_q;
  logic            branch_q;
  logic            illegal_q;
`ifdef ALU_MDU_EN
  logic            isMop;
`endif

  function automatic logic [XLEN-1:0] baseOp(input logic [2:0] f, input logic [XLEN-1:0] a,
                                             input logic [XLEN-1:0] b);
    logic [SW-1:0] sh;
    sh = b[SW-1:0];
    case (f)
      3'd0:    return a + b;
      3'd1:    return a << sh;
      3'd2:    return {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      3'd3:    return {{(XLEN-1){1'b0}}, a < b};
      3'd4:    return a ^ b;
      3'd5:    return a >> sh;
      3'd6:    return a | b;
      default: return a & b;
    endcase
  endfunction

  assign sraRes = $signed(op_a) >>> op_b[SW-1:0];

  // Single-cycle decode; anything flagged illegal leaves the result at zero.
  always_comb begin
    aluRes = '0;
    aluBr  = 1'b0;
    aluIll = 1'b0;
`ifdef ALU_MDU_EN
    isMop  = 1'b0;
`endif
    case (fmt)
      4'd0: begin
        case (funct7)
          7'h00: aluRes = baseOp(funct3, op_a, op_b);
          7'h20: begin
            if (funct3 == 3'd0)      aluRes = op_a - op_b;
            else if (funct3 == 3'd5) aluRes = sraRes;
            else                     aluIll = 1'b1;
          end
          7'h01: begin
`ifdef ALU_MDU_EN
            isMop = 1'b1;
`else
            aluIll = 1'b1;
`endif
          end
          default: aluIll = 1'b1;
        endcase
      end
      4'd1: begin
        if (funct3 == 3'd1 && funct7 != 7'h00) aluIll = 1'b1;
        else if (funct3 == 3'd5) begin
          if (funct7 == 7'h20)      aluRes = sraRes;
          else if (funct7 == 7'h00) aluRes = baseOp(funct3, op_a, op_b);
          else                      aluIll = 1'b1;
        end else aluRes = baseOp(funct3, op_a, op_b);
      end
      4'd5: begin
        aluRes = op_a + op_b;
        case (funct3)
          3'd0:    aluBr = (op_a == op_b);
          3'd1:    aluBr = (op_a != op_b);
          3'd4:    aluBr = ($signed(op_a) <  $signed(op_b));
          3'd5:    aluBr = ($signed(op_a) >= $signed(op_b));
          3'd6:    aluBr = (op_a <  op_b);
          3'd7:    aluBr = (op_a >= op_b);
          default: begin
            aluIll = 1'b1;
            aluRes = '0;
          end
        endcase
      end
      default: aluRes = op_a + op_b;
    endcase
  end

`ifdef ALU_MDU_EN
  localparam int CW = $clog2(XLEN+1);
  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     count_q;
  logic [2*XLEN-1:0] acc_q, accStep, prod;
  logic [XLEN-1:0]   opnd_q, magA, magB, addend, divDiff, quo, rem, finRes;
  logic [XLEN:0]     addSum, divShift;
  logic [2:0]        f3_q;
  logic              negA, negB, negA_q, negB_q, divZero_q, lastIter, accept;

  assign accept   = start && (state_q != CALC);
  assign lastIter = (count_q == CW'(XLEN));

  always_comb begin
    state_d = state_q;
    case (state_q)
      CALC:    if (lastIter) state_d = FIN;
      default: state_d = (accept && isMop) ? CALC : IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Operands enter the engine as magnitudes; the recorded signs are reapplied on completion.
  always_comb begin
    negA = op_a[XLEN-1] && (funct3 == 3'd1 || funct3 == 3'd2 || funct3 == 3'd4 || funct3 == 3'd6);
    negB = op_b[XLEN-1] && (funct3 == 3'd1 || funct3 == 3'd4 || funct3 == 3'd6);
    magA = negA ? -op_a : op_a;
    magB = negB ? -op_b : op_b;
  end

  // acc_q holds {partial product, multiplier} or {partial remainder, dividend/quotient}.
  always_comb begin
    addend   = acc_q[0] ? opnd_q : '0;
    addSum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, addend};
    divShift = acc_q[2*XLEN-1:XLEN-1];
    divDiff  = divShift[XLEN-1:0] - opnd_q;
    if (!f3_q[2])                        accStep = {addSum, acc_q[XLEN-1:1]};
    else if (divShift >= {1'b0, opnd_q}) accStep = {divDiff, acc_q[XLEN-2:0], 1'b1};
    else                                 accStep = {divShift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
  end

  always_comb begin
    prod = (negA_q ^ negB_q) ? -acc_q : acc_q;
    quo  = acc_q[XLEN-1:0];
    rem  = acc_q[2*XLEN-1:XLEN];
    case (f3_q)
      3'd0:       finRes = prod[XLEN-1:0];
      3'd1, 3'd2,
      3'd3:       finRes = prod[2*XLEN-1:XLEN];
      3'd4, 3'd5: finRes = divZero_q ? '1 : ((negA_q ^ negB_q) ? -quo : quo);
      default:    finRes = negA_q ? -rem : rem;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_q  <= '0;
      done_q    <= 1'b0;
      branch_q  <= 1'b0;
      illegal_q <= 1'b0;
      acc_q     <= '0;
      opnd_q    <= '0;
      count_q   <= '0;
      f3_q      <= '0;
      negA_q    <= 1'b0;
      negB_q    <= 1'b0;
      divZero_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q == CALC) begin
        if (lastIter) begin
          result_q  <= finRes;
          branch_q  <= 1'b0;
          illegal_q <= 1'b0;
          done_q    <= 1'b1;
        end else begin
          acc_q   <= accStep;
          count_q <= count_q + CW'(1);
        end
      end else if (start) begin
        if (isMop) begin
          f3_q      <= funct3;
          negA_q    <= negA;
          negB_q    <= negB;
          divZero_q <= (op_b == '0);
          count_q   <= '0;
          if (funct3[2]) begin
            acc_q  <= {{XLEN{1'b0}}, magA};
            opnd_q <= magB;
          end else begin
            acc_q  <= {{XLEN{1'b0}}, magB};
            opnd_q <= magA;
          end
        end else begin
          result_q  <= aluRes;
          branch_q  <= aluBr;
          illegal_q <= aluIll;
          done_q    <= 1'b1;
        end
      end
    end
  end

  assign busy = (state_q == CALC);
`else
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_q  <= '0;
      done_q    <= 1'b0;
      branch_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        result_q  <= aluRes;
        branch_q  <= aluBr;
        illegal_q <= aluIll;
        done_q    <= 1'b1;
      end
    end
  end

  assign busy = 1'b0;
`endif

  assign done         = done_q;
  assign result       = result_q;
  assign branch_taken = branch_q;
  assign illegal      = illegal_q;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed cases plus random operations checked
// against an arithmetic reference model (M-op expectations follow ALU_MDU_EN).
module tb_alu_exec_unit;
  localparam int XLEN = 32;
`ifdef ALU_MDU_EN
  localparam bit MDU = 1'b1;
`else
  localparam bit MDU = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  fmt = '0;
  logic [2:0]  funct3 = '0;
  logic [6:0]  funct7 = '0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        busy, done, branch_taken, illegal;
  logic [31:0] result;

  int          vecCount = 0;
  int          errCount = 0;
  logic [31:0] obs;
  int          lat;
  int          pulses;

  alu_exec_unit #(.XLEN(XLEN)) dut (
    .clk(clk), .reset(reset), .start(start), .fmt(fmt), .funct3(funct3), .funct7(funct7),
    .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .result(result),
    .branch_taken(branch_taken), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Multiply/divide outcomes from wide integer arithmetic.
  function automatic logic [31:0] mulDiv(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = 64'(a);
    ub = 64'(b);
    case (f3)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin if (b == 0) return 32'hFFFFFFFF; p = sa / sb; return p[31:0]; end
      3'd5: begin if (b == 0) return 32'hFFFFFFFF; return a / b; end
      3'd6: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
      default: begin if (b == 0) return a; return a % b; end
    endcase
  endfunction

  function automatic void refModel(input logic [3:0] f, input logic [2:0] f3, input logic [6:0] f7,
                                   input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] res, output logic br, output logic ill,
                                   output logic mop);
    int          kind;
    logic [31:0] ones;
    logic [4:0]  sh;
    ones = '1;
    sh   = b[4:0];
    res  = a + b;
    br   = 1'b0;
    ill  = 1'b0;
    mop  = 1'b0;
    kind = -1;
    if (f == 4'd0) begin
      if (f7 == 7'h00)                  kind = int'(f3);
      else if (f7 == 7'h20 && f3 == 0)  kind = 8;
      else if (f7 == 7'h20 && f3 == 5)  kind = 9;
      else if (f7 == 7'h01)             kind = MDU ? 10 : 11;
      else                              kind = 11;
    end else if (f == 4'd1) begin
      if (f3 == 1)      kind = (f7 == 7'h00) ? 1 : 11;
      else if (f3 == 5) kind = (f7 == 7'h20) ? 9 : ((f7 == 7'h00) ? 5 : 11);
      else              kind = int'(f3);
    end else if (f == 4'd5) begin
      case (f3)
        3'd0:    br = (a == b);
        3'd1:    br = (a != b);
        3'd4:    br = ($signed(a) < $signed(b));
        3'd5:    br = !($signed(a) < $signed(b));
        3'd6:    br = (a < b);
        3'd7:    br = !(a < b);
        default: ill = 1'b1;
      endcase
    end
    case (kind)
      0:  res = a + b;
      1:  res = a << sh;
      2:  res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3:  res = (a < b) ? 32'd1 : 32'd0;
      4:  res = a ^ b;
      5:  res = a >> sh;
      6:  res = a | b;
      7:  res = a & b;
      8:  res = a - b;
      9:  res = (a >> sh) | (a[31] ? ~(ones >> sh) : 32'd0);
      10: begin mop = 1'b1; res = mulDiv(f3, a, b); end
      11: ill = 1'b1;
      default: ;
    endcase
    if (ill) res = '0;
  endfunction

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h80000000;
      2:       return 32'hFFFFFFFF;
      3:       return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vecCount++;
    assert (observed === expected)
    else begin
      errCount++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  // Issues one start pulse, scrambles inputs afterwards, then waits (bounded) for done.
  task automatic applyStimulus(input logic [3:0] f, input logic [2:0] f3, input logic [6:0] f7,
                               input logic [31:0] a, input logic [31:0] b,
                               output int latency, output logic seen, output logic busy0);
    @(negedge clk);
    fmt = f; funct3 = f3; funct7 = f7; op_a = a; op_b = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    op_a = $urandom; op_b = $urandom;
    fmt = 4'($urandom); funct3 = 3'($urandom); funct7 = 7'($urandom);
    busy0   = busy;
    latency = 0;
    seen    = 1'b0;
    while (!seen && latency < 100) begin
      if (done === 1'b1) seen = 1'b1;
      else begin
        @(negedge clk);
        latency++;
      end
    end
  endtask

  task automatic checkOp(input string tag, input logic [3:0] f, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] a, input logic [31:0] b, output logic [31:0] observed);
    logic [31:0] eRes;
    logic        eBr, eIll, eMop, seen, busy0;
    int          latency;
    refModel(f, f3, f7, a, b, eRes, eBr, eIll, eMop);
    applyStimulus(f, f3, f7, a, b, latency, seen, busy0);
    checkOutput({tag, ".done"}, 32'(seen), 32'd1);
    checkOutput({tag, ".lat"}, 32'(latency), eMop ? 32'd33 : 32'd0);
    checkOutput({tag, ".busy"}, 32'(busy0), 32'(eMop));
    checkOutput({tag, ".res"}, result, eRes);
    checkOutput({tag, ".br"}, 32'(branch_taken), 32'(eBr));
    checkOutput({tag, ".ill"}, 32'(illegal), 32'(eIll));
    observed = result;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    checkOutput("rst.busy", 32'(busy), 32'd0);
    checkOutput("rst.done", 32'(done), 32'd0);
    checkOutput("rst.res", result, 32'd0);
    checkOutput("rst.br", 32'(branch_taken), 32'd0);
    checkOutput("rst.ill", 32'(illegal), 32'd0);
    reset = 1'b0;

    checkOp("add", 4'd0, 3'd0, 7'h00, 32'd5, 32'd7, obs);
    checkOutput("add.plan", obs, 32'd12);
    checkOp("sub", 4'd0, 3'd0, 7'h20, 32'd5, 32'd7, obs);
    checkOutput("sub.plan", obs, 32'hFFFFFFFE);
    checkOp("sra", 4'd0, 3'd5, 7'h20, 32'h80000010, 32'd4, obs);
    checkOutput("sra.plan", obs, 32'hF8000001);
    checkOp("sltu", 4'd0, 3'd3, 7'h00, 32'd1, 32'hFFFFFFFF, obs);
    checkOutput("sltu.plan", obs, 32'd1);
    checkOp("slt", 4'd0, 3'd2, 7'h00, 32'd1, 32'hFFFFFFFF, obs);
    checkOutput("slt.plan", obs, 32'd0);
    checkOp("blt", 4'd5, 3'd4, 7'h00, 32'hFFFFFFFF, 32'd1, obs);
    checkOutput("blt.plan", 32'(branch_taken), 32'd1);
    checkOp("bltu", 4'd5, 3'd6, 7'h00, 32'hFFFFFFFF, 32'd1, obs);
    checkOutput("bltu.plan", 32'(branch_taken), 32'd0);
    checkOp("bill", 4'd5, 3'd2, 7'h00, 32'd3, 32'd4, obs);
    checkOutput("bill.plan", 32'(illegal), 32'd1);
    checkOp("rill", 4'd0, 3'd0, 7'h10, 32'd3, 32'd4, obs);
    checkOp("islli", 4'd1, 3'd1, 7'h20, 32'd3, 32'd4, obs);
    checkOp("isrx", 4'd1, 3'd5, 7'h10, 32'd3, 32'd4, obs);
    checkOp("iadd", 4'd1, 3'd0, 7'h20, 32'd3, 32'd4, obs);
    checkOp("fmtU", 4'd8, 3'd5, 7'h20, 32'h10, 32'h20, obs);
    checkOp("fmtX", 4'd15, 3'd2, 7'h01, 32'hFFFFFFFF, 32'd2, obs);

    // MULH with a second start mid-operation that must be ignored while busy.
    @(negedge clk);
    fmt = 4'd0; funct3 = 3'd1; funct7 = 7'h01; op_a = 32'h80000000; op_b = 32'd2; start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    lat    = -1;
    pulses = 0;
    checkOutput("mulh.busy", 32'(busy), 32'(MDU));
    for (int n = 0; n < 45; n++) begin
      if (done === 1'b1) begin
        pulses++;
        if (lat < 0) lat = n;
      end
      if (n == 5) begin
        fmt = 4'd0; funct3 = 3'd0; funct7 = 7'h00; op_a = 32'd1; op_b = 32'd1; start = 1'b1;
      end else start = 1'b0;
      @(negedge clk);
    end
    checkOutput("mulh.lat", 32'(lat), MDU ? 32'd33 : 32'd0);
    checkOutput("mulh.pulses", 32'(pulses), MDU ? 32'd1 : 32'd2);
    checkOutput("mulh.res", result, MDU ? 32'hFFFFFFFF : 32'd2);

    checkOp("div", 4'd0, 3'd4, 7'h01, 32'hFFFFFFF9, 32'd2, obs);
    checkOutput("div.plan", obs, MDU ? 32'hFFFFFFFD : 32'd0);
    checkOp("rem", 4'd0, 3'd6, 7'h01, 32'hFFFFFFF9, 32'd2, obs);
    checkOutput("rem.plan", obs, MDU ? 32'hFFFFFFFF : 32'd0);
    checkOp("div0", 4'd0, 3'd4, 7'h01, 32'hFFFFFFF9, 32'd0, obs);
    checkOutput("div0.plan", obs, MDU ? 32'hFFFFFFFF : 32'd0);
    checkOp("remu0", 4'd0, 3'd7, 7'h01, 32'd9, 32'd0, obs);
    checkOutput("remu0.plan", obs, MDU ? 32'd9 : 32'd0);
    checkOp("divov", 4'd0, 3'd4, 7'h01, 32'h80000000, 32'hFFFFFFFF, obs);
    checkOutput("divov.plan", obs, MDU ? 32'h80000000 : 32'd0);
    checkOp("remov", 4'd0, 3'd6, 7'h01, 32'h80000000, 32'hFFFFFFFF, obs);
    checkOutput("remov.plan", obs, 32'd0);

    // A new start in the very cycle done is high must be accepted.
    checkOp("mulb2b", 4'd0, 3'd0, 7'h01, 32'd6, 32'd7, obs);
    fmt = 4'd0; funct3 = 3'd0; funct7 = 7'h00; op_a = 32'd10; op_b = 32'd20; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("b2b.done", 32'(done), 32'd1);
    checkOutput("b2b.busy", 32'(busy), 32'd0);
    checkOutput("b2b.res", result, 32'd30);

    // Reset partway through a DIVU aborts it without a done pulse.
    checkOp("add34", 4'd0, 3'd0, 7'h00, 32'd3, 32'd4, obs);
    @(negedge clk);
    fmt = 4'd0; funct3 = 3'd5; funct7 = 7'h01; op_a = 32'd100; op_b = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("abort.busy", 32'(busy), 32'd0);
    checkOutput("abort.done", 32'(done), 32'd0);
    checkOutput("abort.res", result, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("abort.nodone", 32'(done), 32'd0);
    end
    checkOp("add11", 4'd0, 3'd0, 7'h00, 32'd1, 32'd1, obs);
    checkOutput("add11.plan", obs, 32'd2);

    for (int i = 0; i < 120; i++) begin
      logic [3:0]  f;
      logic [6:0]  f7;
      int          sel;
      sel = $urandom_range(0, 9);
      f = (sel < 4) ? 4'd0 : (sel < 6) ? 4'd1 : (sel < 8) ? 4'd5 : 4'($urandom_range(2, 15));
      case ($urandom_range(0, 7))
        0, 1, 2: f7 = 7'h00;
        3:       f7 = 7'h20;
        4, 5:    f7 = 7'h01;
        default: f7 = 7'($urandom);
      endcase
      checkOp("rnd", f, 3'($urandom), f7, pickOperand(), pickOperand(), obs);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end
endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Registered RV-style execute unit: decodes fmt/funct3/funct7 and computes the result in one block.
- Generalises the combinational ALU control decode to XLEN-wide operands.
- Adds SRA and SLTU, a registered branch-compare flag, and an iterative M-extension multiply/divide engine with a start/busy/done handshake.
- Sits between register read and writeback in the core datapath.

Parameters:
- XLEN, 32, operand/result width (32 or 64). Shift amount uses the low $clog2(XLEN) bits of op_b.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  issue request; sampled only when busy=0
- fmt  in  4  format code: R=0, I=1, IL=2, IE=3, S=4, B=5, J=6, JI=7, U=8, UP=9
- funct3  in  3  instruction funct3
- funct7  in  7  instruction funct7
- op_a  in  XLEN  operand A (rs1/pc)
- op_b  in  XLEN  operand B (rs2/imm)
- busy  out  1  multi-cycle operation in progress
- done  out  1  one-cycle pulse: result, branch_taken and illegal valid
- result  out  XLEN  registered result; held until the next done
- branch_taken  out  1  registered compare outcome for B-type
- illegal  out  1  registered; unsupported fmt/funct combination

Behaviour:
- Reset (async): state=IDLE; busy, done, result, branch_taken, illegal all 0; iteration counter 0. Reset mid-operation aborts it; no done is produced.
- States: IDLE -> (start & M-op) CALC -> (counter == XLEN) FIN -> IDLE.
  - FIN is the cycle that applies sign correction and pulses done.
  - Single-cycle ops never leave IDLE.
- Single-cycle latency: start sampled at edge T0; done=1 for the cycle following T0 with result valid; busy stays 0.
- M-op latency: busy=1 from T0; XLEN iteration edges T1..TXLEN; done=1 and busy=0 after edge TXLEN+1. This latency is fixed for every M-op, including divide-by-zero and overflow.
- start while busy=1 is ignored. Back-to-back start in the cycle done is high is accepted. Operands and funct fields are captured at T0, so input changes after T0 have no effect.
- R decode, funct7=0x00:
  - funct3 0..7 = ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND.
- R decode, funct7=0x20: funct3=0 SUB, funct3=5 SRA.
- R decode, funct7=0x01 (M-op, funct3 0..7):
  - 0..3 = MUL, MULH, MULHSU, MULHU.
  - 4..7 = DIV, DIVU, REM, REMU.
- Any other R combination: illegal=1 and result=0, flagged with the single-cycle done.
- I decode: same as R with funct7 ignored, except funct3=5 (funct7=0x20 -> SRA, 0x00 -> SRL, else illegal) and funct3=1 (funct7 must be 0x00).
- B decode: funct3 0/1/4/5/6/7 = EQ/NE/LT/GE/LTU/GEU.
  - Sets branch_taken; result = op_a + op_b.
  - funct3 2 or 3: illegal=1.
- IL, IE, S, J, JI, U, UP, and unknown fmt: result = op_a + op_b, branch_taken=0.
- SLT/SLTU: result is zero-extended 1/0.
- Shifts use op_b[$clog2(XLEN)-1:0]. SRA replicates op_a[XLEN-1].
- Multiply: shift-add over 2*XLEN accumulator, one bit per cycle; operands converted to magnitude per signedness; product negated in FIN if the signs differ. MUL returns the low half; MULH/MULHSU/MULHU return the high half.
- Divide: restoring, one quotient bit per cycle, on magnitudes; FIN applies sign (quotient negative if signs differ, remainder takes the dividend sign).
- Divide by zero: quotient all ones, remainder = op_a.
- Signed overflow (min / -1): quotient = min, remainder = 0.
- All arithmetic wraps modulo 2^XLEN.

Optional Feature:
- ALU_MDU_EN defined: M-ops are implemented as above.
- ALU_MDU_EN undefined: no multiply/divide datapath. R-type funct7=0x01 is flagged illegal with result=0 and single-cycle done; busy is constant 0.

Test Plan:
- XLEN=32, R ADD a=5 b=7 -> done one cycle after start, result=12, busy never 1. SUB a=5 b=7 -> 0xFFFFFFFE.
- R SRA a=0x80000010 b=4 -> 0xF8000001. SLTU a=1 b=0xFFFFFFFF -> 1. SLT same operands -> 0.
- B LT a=0xFFFFFFFF b=1 -> branch_taken=1. LTU same operands -> 0. B funct3=2 -> illegal=1.
- MULH a=0x80000000 b=2 -> done exactly 33 cycles after the start edge, result=0xFFFFFFFF. A second start at cycle 5 is ignored; only one done pulse.
- DIV a=-7 b=2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF. DIV by 0 -> 0xFFFFFFFF; REMU a=9 by 0 -> 9. DIV 0x80000000 by -1 -> 0x80000000, REM -> 0.
- Assert reset 10 cycles into a DIVU -> busy/done/result go 0 immediately. Release reset, then ADD 1+1 -> result 2 one cycle later.
